// File: rtl/ebus_master.sv
// rtl/ebus_master.sv - Z80 external bus initiator (optional busack timeout: EBUS_MASTER_TIMEOUT_EN)
module ebus_master #(
  parameter int MEM_TICKS  = 2,
  parameter int IO_TICKS   = 3,
  parameter int HOLD_TICKS = 4,
  parameter int TO_TICKS   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ebus_phi,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wrdata,
  output logic        rsp_done,
  output logic [7:0]  rsp_rddata,
  output logic        rsp_err,
  output logic        busreq,
  input  logic        busack_n,
  output logic        bus_en,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_mreq_n,
  output logic        bus_iorq_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_STROBE, S_HOLD, S_OWNED, S_REL
  } state_t;

  localparam logic [7:0] MEM_T  = 8'(MEM_TICKS);
  localparam logic [7:0] IO_T   = 8'(IO_TICKS);
  localparam logic [7:0] HOLD_T = 8'(HOLD_TICKS);
  localparam logic [7:0] TO_T   = 8'(TO_TICKS);

  state_t      state;
  logic        phi_q;
  logic        ack_s1;
  logic        ack_s2;
  logic [7:0]  cnt;
  logic        done_nxt;
  logic        lat_write;
  logic        lat_io;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wrdata;

  logic        tick;
  logic        granted;
  logic        accept;
  logic [7:0]  cnt_inc;
  logic [7:0]  strobe_len;

  assign tick       = ebus_phi & ~phi_q;
  assign granted    = ~ack_s2;
  assign accept     = req_valid & req_ready;
  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign strobe_len = lat_io ? IO_T : MEM_T;

`ifndef EBUS_MASTER_TIMEOUT_EN
  // Without the timeout the REQ wait is unbounded and the limit has no consumer.
  logic unused_to;
  assign unused_to = |TO_T;
`endif

  // Edge detect on phi and two-flop synchroniser for the asynchronous busack_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi_q  <= 1'b0;
      ack_s1 <= 1'b1;
      ack_s2 <= 1'b1;
    end else begin
      phi_q  <= ebus_phi;
      ack_s1 <= busack_n;
      ack_s2 <= ack_s1;
    end
  end

  // Bus ownership and cycle sequencer; all bus-facing outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      done_nxt   <= 1'b0;
      lat_write  <= 1'b0;
      lat_io     <= 1'b0;
      lat_addr   <= 16'd0;
      lat_wrdata <= 8'd0;
      req_ready  <= 1'b0;
      rsp_done   <= 1'b0;
      rsp_rddata <= 8'd0;
      rsp_err    <= 1'b0;
      busreq     <= 1'b0;
      bus_en     <= 1'b0;
      bus_a      <= 16'd0;
      bus_d_out  <= 8'd0;
      bus_d_oe   <= 1'b0;
      bus_rd_n   <= 1'b1;
      bus_wr_n   <= 1'b1;
      bus_mreq_n <= 1'b1;
      bus_iorq_n <= 1'b1;
    end else begin
      rsp_done <= done_nxt;
      done_nxt <= 1'b0;
      rsp_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write  <= req_write;
            lat_io     <= req_io;
            lat_addr   <= req_addr;
            lat_wrdata <= req_wrdata;
            req_ready  <= 1'b0;
            busreq     <= 1'b1;
            cnt        <= 8'd0;
            state      <= S_REQ;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_REQ: begin
          if (tick) begin
            if (granted) begin
              bus_en   <= 1'b1;
              bus_a    <= lat_addr;
              bus_d_oe <= lat_write;
              if (lat_write) bus_d_out <= lat_wrdata;
              state    <= S_ADDR;
            end
`ifdef EBUS_MASTER_TIMEOUT_EN
            else if (cnt_inc >= TO_T) begin
              busreq  <= 1'b0;
              rsp_err <= 1'b1;
              state   <= S_REL;
            end else begin
              cnt <= cnt_inc;
            end
`endif
          end
        end
        S_ADDR: begin
          if (tick) begin
            cnt <= 8'd0;
            if (lat_io) bus_iorq_n <= 1'b0;
            else        bus_mreq_n <= 1'b0;
            if (lat_write) bus_wr_n <= 1'b0;
            else           bus_rd_n <= 1'b0;
            state <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (tick) begin
            if (cnt_inc >= strobe_len) begin
              bus_rd_n   <= 1'b1;
              bus_wr_n   <= 1'b1;
              bus_mreq_n <= 1'b1;
              bus_iorq_n <= 1'b1;
              if (!lat_write) rsp_rddata <= bus_d_in;
              done_nxt   <= 1'b1;
              state      <= S_HOLD;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            bus_d_oe <= 1'b0;
            cnt      <= 8'd0;
            if (HOLD_T == 8'd0) begin
              bus_en <= 1'b0;
              busreq <= 1'b0;
              state  <= S_REL;
            end else begin
              req_ready <= 1'b1;
              state     <= S_OWNED;
            end
          end
        end
        S_OWNED: begin
          // A new request beats an idle-timer expiry landing on the same clk.
          if (accept) begin
            lat_write  <= req_write;
            lat_io     <= req_io;
            lat_addr   <= req_addr;
            lat_wrdata <= req_wrdata;
            req_ready  <= 1'b0;
            cnt        <= 8'd0;
            bus_a      <= req_addr;
            bus_d_oe   <= req_write;
            if (req_write) bus_d_out <= req_wrdata;
            state      <= S_ADDR;
          end else if (tick) begin
            if (cnt_inc >= HOLD_T) begin
              req_ready <= 1'b0;
              bus_en    <= 1'b0;
              busreq    <= 1'b0;
              state     <= S_REL;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_REL: begin
          if (!granted) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
